// File: rtl/seq_det_pkg.sv
// Shared definitions for the serializer and the serial sequence detectors it feeds.
// Bit-order constants keep producer and consumers agreeing on which end of a word goes first.
package seq_det_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam bit BIT_ORDER_MSB = 1'b1;
    localparam bit BIT_ORDER_LSB = 1'b0;

endpackage

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder with a one-word holding register, so back-to-back words
// stream with no idle bit. All outputs decode from registers; nothing is combinational from din_valid.
module bit_stream_serializer
    import seq_det_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = BIT_ORDER_MSB,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              word_done,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    ser_state_t        state;
    ser_state_t        state_next;
    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;

    logic accept;
    logic load;
    logic advance;
    logic last_bit;

    // Bit currently presented at the output end of the shifter.
    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    assign accept    = din_valid && !hold_full;
    assign last_bit  = (cnt == LAST_CNT);
    assign din_ready = !hold_full;
    assign busy      = (state == SER_SHIFT) || hold_full;

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        advance     = 1'b0;
        ser_out     = IDLE_BIT;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        word_done   = 1'b0;
        case (state)
            SER_IDLE: begin
                if (hold_full) begin
                    load       = 1'b1;
                    state_next = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                ser_out     = head_bit(sr);
                ser_valid   = 1'b1;
                frame_start = (cnt == '0);
                word_done   = last_bit;
                if (!last_bit) begin
                    advance = 1'b1;
                end else if (hold_full) begin
                    // Reload straight from the hold slot so the next word follows without a gap.
                    load = 1'b1;
                end else begin
                    state_next = SER_IDLE;
                end
            end
            default: state_next = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SER_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accept and load never coincide: accept needs an empty slot, load needs a full one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= hold;
            cnt <= '0;
        end else if (advance) begin
            sr  <= shift_one(sr);
            cnt <= cnt + CNT_W'(1);
        end else if (state_next == SER_IDLE) begin
            cnt <= '0;
        end
    end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench: two serializer instances (MSB-first and LSB-first) share inputs;
// expected bit sequences and handshake timing are hand-derived constants.
module tb_bit_stream_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;

    logic a_ready, a_ser_out, a_ser_valid, a_frame_start, a_word_done, a_busy;
    logic b_ready, b_ser_out, b_ser_valid, b_frame_start, b_word_done, b_busy;

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] stream = '0;

    always #5 clk = ~clk;

    bit_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(a_ready), .ser_out(a_ser_out), .ser_valid(a_ser_valid),
        .frame_start(a_frame_start), .word_done(a_word_done), .busy(a_busy)
    );

    bit_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(b_ready), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
        .frame_start(b_frame_start), .word_done(b_word_done), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one full word on the chosen instance, starting with its first bit visible now.
    task automatic word_check(input string tag, input logic [7:0] w, input bit lsb);
        for (int i = 0; i < 8; i++) begin
            logic exp_bit;
            logic got_bit;
            exp_bit = lsb ? w[i] : w[7-i];
            got_bit = lsb ? b_ser_out : a_ser_out;
            stream  = {stream[14:0], got_bit};
            check($sformatf("%s b%0d ser_valid", tag, i), lsb ? b_ser_valid : a_ser_valid, 1);
            check($sformatf("%s b%0d ser_out", tag, i), got_bit, exp_bit);
            check($sformatf("%s b%0d frame_start", tag, i), lsb ? b_frame_start : a_frame_start, (i == 0));
            check($sformatf("%s b%0d word_done", tag, i), lsb ? b_word_done : a_word_done, (i == 7));
            check($sformatf("%s b%0d busy", tag, i), lsb ? b_busy : a_busy, 1);
            step();
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        din       = w;
        din_valid = 1'b1;
        check("send ready", a_ready, 1);
        step();
        din_valid = 1'b0;
        check("held busy", a_busy, 1);
        check("held ready", a_ready, 0);
        check("held idle ser_valid", a_ser_valid, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n110;
        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        #1;
        check("rst din_ready", a_ready, 1);
        check("rst ser_out", a_ser_out, 0);
        check("rst ser_valid", a_ser_valid, 0);
        check("rst frame_start", a_frame_start, 0);
        check("rst word_done", a_word_done, 0);
        check("rst busy", a_busy, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Single word, MSB first
        send_word(8'hD9);
        word_check("t1", 8'hD9, 1'b0);
        check("t1 idle ser_valid", a_ser_valid, 0);
        check("t1 idle ser_out", a_ser_out, 0);
        check("t1 idle busy", a_busy, 0);
        step();

        // Two words back to back with no gap
        din       = 8'hC6;
        din_valid = 1'b1;
        check("t2 ready0", a_ready, 1);
        step();
        check("t2 ready1", a_ready, 0);
        step();
        fork
            begin
                word_check("t2w1", 8'hC6, 1'b0);
                word_check("t2w2", 8'hC6, 1'b0);
            end
            begin
                check("t2 ready reopen", a_ready, 1);
                step();
                din_valid = 1'b0;
                check("t2 ready after 2nd", a_ready, 0);
            end
        join
        check("t2 stream", stream, 16'hC6C6);
        n110 = 0;
        for (int i = 0; i < 14; i++) begin
            if (stream[15-i] && stream[14-i] && !stream[13-i]) n110++;
        end
        check("t2 count110", n110, 4);
        check("t2 idle ser_valid", a_ser_valid, 0);
        step();

        // din_valid held for three words
        din       = 8'hA1;
        din_valid = 1'b1;
        check("t3 ready0", a_ready, 1);
        step();
        check("t3 ready1", a_ready, 0);
        din = 8'hB2;
        step();
        fork
            begin
                word_check("t3w1", 8'hA1, 1'b0);
                word_check("t3w2", 8'hB2, 1'b0);
                word_check("t3w3", 8'hC3, 1'b0);
            end
            begin
                check("t3 ready after load1", a_ready, 1);
                step();
                check("t3 ready after acc2", a_ready, 0);
                din = 8'hC3;
                for (int k = 3; k <= 8; k++) begin
                    step();
                    check($sformatf("t3 ready hold e%0d", k), a_ready, 0);
                end
                step();
                check("t3 ready after load2", a_ready, 1);
                step();
                check("t3 ready after acc3", a_ready, 0);
                din_valid = 1'b0;
            end
        join
        check("t3 idle ser_valid", a_ser_valid, 0);
        check("t3 idle busy", a_busy, 0);
        step();

        // LSB-first instance
        send_word(8'h03);
        word_check("t4", 8'h03, 1'b1);
        check("t4 idle ser_valid", b_ser_valid, 0);
        step();

        // Reset mid-word with a second word held
        din       = 8'hD9;
        din_valid = 1'b1;
        step();
        din = 8'h5A;
        step();
        step();
        din_valid = 1'b0;
        check("t5 held", a_ready, 0);
        step();
        check("t5 bit3", a_ser_out, 0);
        reset = 1'b1;
        #1;
        check("t5 rst ser_out", a_ser_out, 0);
        check("t5 rst ser_valid", a_ser_valid, 0);
        check("t5 rst busy", a_busy, 0);
        check("t5 rst ready", a_ready, 1);
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t5 post-rst ser_valid %0d", k), a_ser_valid, 0);
            check($sformatf("t5 post-rst busy %0d", k), a_busy, 0);
        end
        send_word(8'h81);
        word_check("t5 next", 8'h81, 1'b0);

        // Words separated by 5-cycle gaps
        check("t6 busy drop w0", a_busy, 0);
        for (int w = 0; w < 2; w++) begin
            for (int g = 0; g < 5; g++) begin
                check($sformatf("t6 gap%0d.%0d ser_valid", w, g), a_ser_valid, 0);
                check($sformatf("t6 gap%0d.%0d ser_out", w, g), a_ser_out, 0);
                step();
            end
            send_word(w == 0 ? 8'h35 : 8'h9C);
            word_check($sformatf("t6w%0d", w), w == 0 ? 8'h35 : 8'h9C, 1'b0);
            check($sformatf("t6 busy drop w%0d", w + 1), a_busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
